// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop line synchroniser, centre sampling of every bit,
// optional odd/even parity, one or two stop bits, and frame/break detection.
module uart_rx_cfg #(
    parameter int CLK_PER_BIT = 868,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_busy
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLK_PER_BIT - 1) / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   ferr_acc_q, ferr_acc_d;
    logic                   seen_high_q, seen_high_d;
    logic                   sync1_q, rx_s_q;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   brk_q, brk_d;
    logic                   par_sum;

    // Synchroniser resets to the idle-high level so a reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= i_rx;
            rx_s_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            ferr_acc_q  <= 1'b0;
            seen_high_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            ferr_acc_q  <= ferr_acc_d;
            seen_high_q <= seen_high_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            brk_q       <= brk_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        ferr_acc_d  = ferr_acc_q;
        seen_high_d = seen_high_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        brk_d       = brk_q;
        par_sum     = (^shift_q) ^ par_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s_q) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d       = '0;
                    par_d       = 1'b0;
                    ferr_acc_d  = 1'b0;
                    seen_high_d = 1'b0;
                    state_d     = rx_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d       = '0;
                    seen_high_d = seen_high_q | rx_s_q;
                    for (int k = 0; k < DATA_BITS; k++) begin
                        if (idx_q == 4'(k)) shift_d[k] = rx_s_q;
                    end
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d       = '0;
                    par_d       = rx_s_q;
                    seen_high_d = seen_high_q | rx_s_q;
                    state_d     = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d       = '0;
                    ferr_acc_d  = ferr_acc_q | ~rx_s_q;
                    seen_high_d = seen_high_q | rx_s_q;
                    if (idx_q == STOP_LAST) begin
                        // Last stop sample: publish the frame; a bad stop waits for the line to recover.
                        idx_d   = '0;
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        perr_d  = (PARITY == 1) ? ~par_sum : (PARITY == 2) ? par_sum : 1'b0;
                        ferr_d  = ferr_acc_q | ~rx_s_q;
                        brk_d   = ~(seen_high_q | rx_s_q);
                        state_d = (ferr_acc_q | ~rx_s_q) ? ST_WAIT_HIGH : ST_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                cnt_d = '0;
                idx_d = '0;
                if (rx_s_q) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_break      = brk_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: two builds (8E1 and 9N2) driven with directed and random frames,
// checked every cycle against a frame-level model of what each frame must report.
module tb_uart_rx_cfg;

    localparam int CPB = 16;
    localparam int H   = (CPB - 1) / 2;
    localparam int DB1 = 8;
    localparam int PAR1 = 2;
    localparam int ST1 = 1;
    localparam int DB2 = 9;
    localparam int PAR2 = 0;
    localparam int ST2 = 2;

    typedef struct {
        logic [15:0] data;
        logic        perr;
        logic        ferr;
        logic        brk;
        longint      due;
    } exp_t;

    logic clk = 1'b0;
    logic rst1, rst2, rx1, rx2;
    logic [DB1-1:0] data1;
    logic [DB2-1:0] data2;
    logic valid1, perr1, ferr1, brk1, busy1;
    logic valid2, perr2, ferr2, brk2, busy2;

    longint cyc = 0;
    int compared = 0;
    int mismatched = 0;
    exp_t q1[$];
    exp_t q2[$];
    logic [15:0] holdData [1:2];
    logic        holdPe   [1:2];
    logic        holdFe   [1:2];
    logic        holdBk   [1:2];
    longint      tValid   [1:2];

    uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(DB1), .PARITY(PAR1), .STOP_BITS(ST1)) dut1 (
        .clk(clk), .rst(rst1), .i_rx(rx1), .o_data(data1), .o_valid(valid1),
        .o_parity_err(perr1), .o_frame_err(ferr1), .o_break(brk1), .o_busy(busy1)
    );

    uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(DB2), .PARITY(PAR2), .STOP_BITS(ST2)) dut2 (
        .clk(clk), .rst(rst2), .i_rx(rx2), .o_data(data2), .o_valid(valid2),
        .o_parity_err(perr2), .o_frame_err(ferr2), .o_break(brk2), .o_busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // What a frame must report, derived only from the line levels after the start bit.
    function automatic exp_t model(input int w, input logic [15:0] lv, input longint due);
        exp_t e;
        int db, par, nst, idx;
        logic pb, x;
        db  = (w == 1) ? DB1 : DB2;
        par = (w == 1) ? PAR1 : PAR2;
        nst = (w == 1) ? ST1 : ST2;
        e.data = '0;
        e.ferr = 1'b0;
        e.brk  = 1'b1;
        pb = 1'b0;
        x  = 1'b0;
        for (int k = 0; k < db; k++) begin
            e.data[k] = lv[k];
            x = x ^ lv[k];
        end
        idx = db;
        if (par != 0) begin
            pb = lv[idx];
            idx++;
        end
        for (int s = 0; s < nst; s++) begin
            if (!lv[idx]) e.ferr = 1'b1;
            idx++;
        end
        for (int k = 0; k < idx; k++) begin
            if (lv[k]) e.brk = 1'b0;
        end
        e.perr = (par == 1) ? !(x ^ pb) : (par == 2) ? (x ^ pb) : 1'b0;
        e.due  = due;
        return e;
    endfunction

    function automatic logic [15:0] makeLevels(input int w, input logic [8:0] d, input logic parFlip,
                                               input logic [1:0] stopv, output int n);
        logic [15:0] lv;
        int db, par, nst;
        logic x;
        db  = (w == 1) ? DB1 : DB2;
        par = (w == 1) ? PAR1 : PAR2;
        nst = (w == 1) ? ST1 : ST2;
        lv = '0;
        n  = 0;
        x  = 1'b0;
        for (int k = 0; k < db; k++) begin
            lv[n] = d[k];
            x = x ^ d[k];
            n++;
        end
        if (par != 0) begin
            lv[n] = ((par == 2) ? x : ~x) ^ parFlip;
            n++;
        end
        for (int s = 0; s < nst; s++) begin
            lv[n] = stopv[s];
            n++;
        end
        return lv;
    endfunction

    task automatic setLine(input int w, input logic v);
        if (w == 1) rx1 = v;
        else        rx2 = v;
    endtask

    task automatic applyStimulus(input int w, input logic [15:0] lv, input int n, input int gap,
                                 output longint d0);
        exp_t e;
        @(posedge clk);
        #1;
        d0 = cyc;
        e = model(w, lv, d0 + 3 + H + n * CPB);
        if (w == 1) q1.push_back(e);
        else        q2.push_back(e);
        setLine(w, 1'b0);
        for (int j = 0; j < n; j++) begin
            repeat (CPB) @(posedge clk);
            #1;
            setLine(w, lv[j]);
        end
        repeat (CPB) @(posedge clk);
        #1;
        setLine(w, 1'b1);
        repeat (gap) @(posedge clk);
    endtask

    task automatic scoreCycle(input int w, input logic v, input logic [15:0] d,
                              input logic pe, input logic fe, input logic bk);
        exp_t e;
        int sz;
        sz = (w == 1) ? q1.size() : q2.size();
        if (v) begin
            tValid[w] = cyc;
            if (sz == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL spurious_valid dut%0d: got o_valid=1, want 0 (cycle %0d)", w, cyc);
            end else begin
                if (w == 1) e = q1.pop_front();
                else        e = q2.pop_front();
                checkOutput("valid_cycle", cyc, e.due);
                holdData[w] = e.data;
                holdPe[w]   = e.perr;
                holdFe[w]   = e.ferr;
                holdBk[w]   = e.brk;
            end
        end else if (sz != 0) begin
            e = (w == 1) ? q1[0] : q2[0];
            if (cyc > e.due) begin
                checkOutput("valid_missing", v, 1'b1);
                if (w == 1) void'(q1.pop_front());
                else        void'(q2.pop_front());
            end
        end
        checkOutput("data", d, holdData[w]);
        checkOutput("parity_err", pe, holdPe[w]);
        checkOutput("frame_err", fe, holdFe[w]);
        checkOutput("break", bk, holdBk[w]);
    endtask

    always @(negedge clk) begin
        if (rst1) begin
            q1.delete();
            holdData[1] = '0;
            holdPe[1] = 1'b0;
            holdFe[1] = 1'b0;
            holdBk[1] = 1'b0;
        end else begin
            scoreCycle(1, valid1, 16'(data1), perr1, ferr1, brk1);
        end
        if (rst2) begin
            q2.delete();
            holdData[2] = '0;
            holdPe[2] = 1'b0;
            holdFe[2] = 1'b0;
            holdBk[2] = 1'b0;
        end else begin
            scoreCycle(2, valid2, 16'(data2), perr2, ferr2, brk2);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no completion, want $finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        longint d0;
        logic [15:0] lv;
        int n;
        exp_t e;

        tValid[1] = 0;
        tValid[2] = 0;
        rst1 = 1'b1;
        rst2 = 1'b1;
        rx1  = 1'b1;
        rx2  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_data1", data1, 0);
        checkOutput("rst_valid1", valid1, 0);
        checkOutput("rst_flags1", {perr1, ferr1, brk1}, 0);
        checkOutput("rst_busy1", busy1, 0);
        checkOutput("rst_data2", data2, 0);
        checkOutput("rst_busy2", busy2, 0);
        rst1 = 1'b0;
        rst2 = 1'b0;
        repeat (5) @(posedge clk);

        $display("[TB] 0xA5 with correct even parity");
        lv = makeLevels(1, 9'h0A5, 1'b0, 2'b11, n);
        applyStimulus(1, lv, n, 20, d0);
        checkOutput("a5_latency_from_T0", tValid[1] - (d0 + 2), 64'd168);
        checkOutput("a5_data", data1, 8'hA5);
        checkOutput("a5_flags", {perr1, ferr1, brk1}, 3'b000);

        $display("[TB] 0x3C with wrong parity bit");
        lv = makeLevels(1, 9'h03C, 1'b1, 2'b11, n);
        applyStimulus(1, lv, n, 20, d0);
        checkOutput("3c_data", data1, 8'h3C);
        checkOutput("3c_parity_err", perr1, 1'b1);
        checkOutput("3c_frame_err", ferr1, 1'b0);

        $display("[TB] 4-cycle start glitch");
        @(posedge clk);
        #1;
        rx1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("glitch_busy_during", busy1, 1'b1);
        rx1 = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("glitch_busy_after", busy1, 1'b0);
        checkOutput("glitch_data_kept", data1, 8'h3C);

        $display("[TB] 0x55 with low stop bit");
        lv = makeLevels(1, 9'h055, 1'b0, 2'b00, n);
        applyStimulus(1, lv, n, 10, d0);
        checkOutput("55_data", data1, 8'h55);
        checkOutput("55_frame_err", ferr1, 1'b1);
        checkOutput("55_break", brk1, 1'b0);
        checkOutput("55_busy_after_recover", busy1, 1'b0);

        $display("[TB] line held low for 20 bit times");
        @(posedge clk);
        #1;
        d0 = cyc;
        e = model(1, 16'h0000, d0 + 3 + H + 10 * CPB);
        q1.push_back(e);
        rx1 = 1'b0;
        repeat (20 * CPB) @(posedge clk);
        #1;
        checkOutput("break_busy_waithigh", busy1, 1'b1);
        checkOutput("break_flags", {ferr1, brk1}, 2'b11);
        checkOutput("break_data", data1, 8'h00);
        rx1 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("break_busy_released", busy1, 1'b0);

        $display("[TB] reset during data bit 3 on the 9N2 build");
        lv = makeLevels(2, 9'h181, 1'b0, 2'b11, n);
        @(posedge clk);
        #1;
        rx2 = 1'b0;
        for (int j = 0; j < 4; j++) begin
            repeat (CPB) @(posedge clk);
            #1;
            rx2 = lv[j];
        end
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst2 = 1'b1;
        rx2  = 1'b1;
        #1;
        checkOutput("midrst_busy2", busy2, 1'b0);
        checkOutput("midrst_valid2", valid2, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst2 = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #1;
        checkOutput("midrst_no_restart", busy2, 1'b0);
        applyStimulus(2, lv, n, 0, d0);
        checkOutput("181_data", data2, 9'h181);
        lv = makeLevels(2, 9'h0F3, 1'b0, 2'b11, n);
        applyStimulus(2, lv, n, 0, d0);
        checkOutput("0f3_data", data2, 9'h0F3);
        checkOutput("0f3_frame_err", ferr2, 1'b0);

        $display("[TB] random frames, 8E1 build");
        for (int i = 0; i < 30; i++) begin
            logic [8:0] d;
            logic pf;
            logic [1:0] sv;
            d  = 9'($urandom);
            pf = ($urandom_range(0, 3) == 0);
            sv = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            if ($urandom_range(0, 9) == 0) d = 9'h000;
            lv = makeLevels(1, d, pf, sv, n);
            applyStimulus(1, lv, n, $urandom_range(0, 12), d0);
        end

        $display("[TB] random frames, 9N2 build");
        for (int i = 0; i < 15; i++) begin
            logic [8:0] d;
            logic [1:0] sv;
            d  = 9'($urandom);
            sv = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            lv = makeLevels(2, d, 1'b0, sv, n);
            applyStimulus(2, lv, n, $urandom_range(0, 12), d0);
        end

        repeat (40) @(posedge clk);
        #1;
        checkOutput("pending_frames1", q1.size(), 0);
        checkOutput("pending_frames2", q2.size(), 0);
        checkOutput("final_busy", {busy1, busy2}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter CLK_PER_BIT, default 868: clock cycles per bit; legal range 4..65535.
REQ-002 The block SHALL have parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 The block SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 The block SHALL have parameter STOP_BITS, default 1: stop bits checked; legal values 1 or 2.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port i_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-008 The block SHALL have port o_data, output, DATA_BITS bits: last received word, LSB first on the line.
REQ-009 The block SHALL have port o_valid, output, 1 bit: one-cycle pulse per completed frame.
REQ-010 The block SHALL have port o_parity_err, output, 1 bit: parity mismatch of the last frame; always 0 when PARITY=0.
REQ-011 The block SHALL have port o_frame_err, output, 1 bit: a checked stop bit of the last frame sampled low.
REQ-012 The block SHALL have port o_break, output, 1 bit: the last frame was all-zero, with data, parity and all stop samples low.
REQ-013 The block SHALL have port o_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 i_rx SHALL pass through a 2-flop synchroniser; all decisions use the second flop (rx_s).
REQ-015 The clock counter SHALL be $clog2(CLK_PER_BIT) bits wide, and H SHALL equal (CLK_PER_BIT-1)/2 using integer division.
REQ-016 The FSM SHALL have exactly the states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-017 In IDLE the FSM SHALL clear the counter and bit index, and move to START in the cycle after rx_s is first seen low (call the cycle where rx_s is seen low T0).
REQ-018 START SHALL sample rx_s at T0+H: if high (glitch), return to IDLE with no output change; if low, go to DATA.
REQ-019 Data bit k (k=0..DATA_BITS-1) SHALL be sampled at T0+H+(k+1)*CLK_PER_BIT into bit k of a shift/index register.
REQ-020 If PARITY!=0, the parity bit SHALL be sampled at T0+H+(DATA_BITS+1)*CLK_PER_BIT; PARITY=0 SHALL skip the PARITY state and consume no bit time.
REQ-021 Odd parity SHALL require (XOR of data bits XOR parity bit) = 1; even parity SHALL require it = 0; a mismatch SHALL set parity_err.
REQ-022 Stop bit(s) SHALL be sampled at successive bit intervals after the last data or parity sample; any low stop sample SHALL set frame_err.
REQ-023 In the cycle after the final stop sample, o_valid SHALL be 1 for exactly one cycle, and o_data, o_parity_err, o_frame_err and o_break SHALL update in that same cycle.
REQ-024 o_data and the three flags SHALL hold their values until the next o_valid; they SHALL NOT change on a glitch-rejected start.
REQ-025 A frame ending without frame_err SHALL return the FSM to IDLE at the final stop sample, so a start edge beginning half a bit later is caught.
REQ-026 A frame ending with frame_err SHALL move the FSM to WAIT_HIGH, which stays until rx_s=1 and then goes to IDLE; a held-low line SHALL produce no further o_valid.
REQ-027 Any state encoding not listed in REQ-016 SHALL move to IDLE on the next clock.
REQ-028 Frames SHALL not be buffered: there is no ready input, and the consumer must take o_data when o_valid=1.

Reset
REQ-029 While rst=1, asynchronously: FSM=IDLE, counter=0, bit index=0, both synchroniser flops=1, o_data=0, o_valid=0, o_parity_err=0, o_frame_err=0, o_break=0, o_busy=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no o_valid; after release, reception SHALL restart only on a new low on rx_s.

Verification (CLK_PER_BIT=16, DATA_BITS=8, PARITY=2, STOP_BITS=1 unless noted)
REQ-031 Send 0xA5 with parity 0 and stop 1 -> one o_valid, o_data=0xA5, all flags 0, o_valid exactly (H+10*16+1) cycles after T0.
REQ-032 Send 0x3C with parity 1 -> o_valid, o_data=0x3C, o_parity_err=1, o_frame_err=0.
REQ-033 Drive i_rx low for 4 cycles, then high -> no o_valid, o_busy returns to 0, o_data is unchanged.
REQ-034 Send 0x55 with stop bit 0, then hold i_rx high -> o_valid with o_frame_err=1, then WAIT_HIGH, then IDLE.
REQ-035 Hold i_rx low for 20 bit times -> exactly one o_valid with o_data=0x00, o_frame_err=1 and o_break=1; no second o_valid until i_rx returns high.
REQ-036 Assert rst during data bit 3, then release and send 0x81 (DATA_BITS=9, PARITY=0, STOP_BITS=2 build: send 0x181) -> no o_valid for the aborted frame; the next frame is received correctly, with back-to-back frames each producing one o_valid.
